// File: rtl/terminal_pkg.sv
// Shared constants, control codes and state encoding for the 80x30 text terminal.
package terminal_pkg;

    localparam int COLS   = 80;
    localparam int ROWS   = 30;
    localparam int CELLS  = COLS * ROWS;
    localparam int ADDR_W = 12;
    localparam int COL_W  = 7;
    localparam int ROW_W  = 5;

    localparam logic [7:0] BLANK_CHAR = 8'h20;
    localparam logic [7:0] CH_BS      = 8'h08;
    localparam logic [7:0] CH_LF      = 8'h0A;
    localparam logic [7:0] CH_FF      = 8'h0C;
    localparam logic [7:0] CH_CR      = 8'h0D;

    localparam logic [ADDR_W-1:0] ONE_A       = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] COLS_A      = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] LAST_CELL_A = ADDR_W'(CELLS - 1);
    localparam logic [ADDR_W-1:0] LAST_ROW_A  = ADDR_W'(CELLS - COLS);
    localparam logic [COL_W-1:0]  LAST_COL    = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW    = ROW_W'(ROWS - 1);

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_PUT,
        ST_SCROLL_RD,
        ST_SCROLL_WR,
        ST_FILL
    } state_e;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

endpackage

// File: rtl/terminal_cursor.sv
// Cursor row/column counters with linear cell address and scroll-needed flag.
module terminal_cursor
    import terminal_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              home_i,
    input  logic              newline_i,
    input  logic              adv_i,
    input  logic              back_i,
    input  logic              cr_i,
    output logic [COL_W-1:0]  col_o,
    output logic [ROW_W-1:0]  row_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              scroll_o
);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             last_col;
    logic             last_row;
    logic             wrap;

    assign last_col = (col_q == LAST_COL);
    assign last_row = (row_q == LAST_ROW);
    assign wrap     = newline_i || (adv_i && last_col);

    // On the last row a wrap leaves the row alone; the scroll moves the text instead.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (home_i) begin
            col_d = '0;
            row_d = '0;
        end else if (wrap) begin
            col_d = '0;
            if (!last_row) row_d = row_q + ROW_W'(1);
        end else if (adv_i) begin
            col_d = col_q + COL_W'(1);
        end else if (back_i) begin
            if (col_q != '0) col_d = col_q - COL_W'(1);
        end else if (cr_i) begin
            col_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col_o    = col_q;
    assign row_o    = row_q;
    assign addr_o   = ADDR_W'(row_q) * COLS_A + ADDR_W'(col_q);
    assign scroll_o = last_row && wrap;

endmodule

// File: rtl/terminal_writer.sv
// Byte stream to terminal cell writes: cursor, control codes, scroll, clear.
// TERM_WRITER_FF_CLEAR_EN: form feed (0x0C) clears the screen and homes the cursor.
module terminal_writer
    import terminal_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              charValid,
    input  logic [7:0]        charData,
    output logic              charReady,
    output logic [ADDR_W-1:0] textAddress,
    input  logic [7:0]        textReadData,
    output logic              shouldWriteText,
    output logic [7:0]        textWriteData,
    output logic [COL_W-1:0]  cursorCol,
    output logic [ROW_W-1:0]  cursorRow,
    output logic              busy
);

`ifdef TERM_WRITER_FF_CLEAR_EN
    localparam logic FF_CLEAR = 1'b1;
`else
    localparam logic FF_CLEAR = 1'b0;
`endif

    state_e            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        data_q;
    logic              wr_q;
    logic              ready_q;
    logic              busy_q;
    logic              put_adv_q;

    logic              xfer;
    logic              printable;
    logic              is_lf;
    logic              is_bs;
    logic              ff_clr;
    logic              bs_put;
    logic              home;
    logic              adv;
    logic [ADDR_W-1:0] cur_addr;
    logic              scroll;

    always_comb begin
        xfer      = charValid && ready_q && (state_q == ST_IDLE);
        printable = is_printable(charData);
        is_lf     = (charData == CH_LF);
        is_bs     = (charData == CH_BS);
        ff_clr    = FF_CLEAR && (charData == CH_FF);
        bs_put    = is_bs && (cursorCol != '0);
        adv       = (state_q == ST_PUT) && put_adv_q;
        home      = ((state_q == ST_CLEAR) && (cnt_q == LAST_CELL_A))
                 || (xfer && ff_clr);
    end

    terminal_cursor u_cursor (
        .clk_i     (clock),
        .rst_i     (reset),
        .home_i    (home),
        .newline_i (xfer && is_lf),
        .adv_i     (adv),
        .back_i    (xfer && is_bs),
        .cr_i      (xfer && (charData == CH_CR)),
        .col_o     (cursorCol),
        .row_o     (cursorRow),
        .addr_o    (cur_addr),
        .scroll_o  (scroll)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            cnt_q     <= '0;
            addr_q    <= '0;
            data_q    <= BLANK_CHAR;
            wr_q      <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
            put_adv_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_CLEAR: begin
                    wr_q   <= 1'b1;
                    addr_q <= cnt_q;
                    data_q <= BLANK_CHAR;
                    busy_q <= 1'b1;
                    if (cnt_q == LAST_CELL_A) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + ONE_A;
                    end
                end
                ST_IDLE: begin
                    wr_q    <= 1'b0;
                    addr_q  <= cur_addr;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    if (xfer) begin
                        unique case (1'b1)
                            printable: begin
                                wr_q      <= 1'b1;
                                data_q    <= charData;
                                put_adv_q <= 1'b1;
                                ready_q   <= 1'b0;
                                busy_q    <= 1'b1;
                                state_q   <= ST_PUT;
                            end
                            (is_lf && scroll): begin
                                addr_q  <= COLS_A;
                                cnt_q   <= COLS_A;
                                ready_q <= 1'b0;
                                busy_q  <= 1'b1;
                                state_q <= ST_SCROLL_RD;
                            end
                            bs_put: begin
                                wr_q      <= 1'b1;
                                addr_q    <= cur_addr - ONE_A;
                                data_q    <= BLANK_CHAR;
                                put_adv_q <= 1'b0;
                                ready_q   <= 1'b0;
                                busy_q    <= 1'b1;
                                state_q   <= ST_PUT;
                            end
                            ff_clr: begin
                                cnt_q   <= '0;
                                ready_q <= 1'b0;
                                busy_q  <= 1'b1;
                                state_q <= ST_CLEAR;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_PUT: begin
                    wr_q <= 1'b0;
                    if (scroll) begin
                        addr_q  <= COLS_A;
                        cnt_q   <= COLS_A;
                        state_q <= ST_SCROLL_RD;
                    end else begin
                        addr_q  <= cur_addr;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                // textAddress already shows the source cell, so the read data is valid now.
                ST_SCROLL_RD: begin
                    data_q  <= textReadData;
                    addr_q  <= cnt_q - COLS_A;
                    wr_q    <= 1'b1;
                    state_q <= ST_SCROLL_WR;
                end
                ST_SCROLL_WR: begin
                    if (cnt_q == LAST_CELL_A) begin
                        cnt_q   <= LAST_ROW_A;
                        addr_q  <= LAST_ROW_A;
                        data_q  <= BLANK_CHAR;
                        wr_q    <= 1'b1;
                        state_q <= ST_FILL;
                    end else begin
                        cnt_q   <= cnt_q + ONE_A;
                        addr_q  <= cnt_q + ONE_A;
                        wr_q    <= 1'b0;
                        state_q <= ST_SCROLL_RD;
                    end
                end
                ST_FILL: begin
                    if (cnt_q == LAST_CELL_A) begin
                        cnt_q   <= '0;
                        addr_q  <= LAST_ROW_A;
                        wr_q    <= 1'b0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q  <= cnt_q + ONE_A;
                        addr_q <= cnt_q + ONE_A;
                        wr_q   <= 1'b1;
                    end
                end
                default: state_q <= ST_CLEAR;
            endcase
        end
    end

    assign charReady       = ready_q;
    assign textAddress     = addr_q;
    assign textWriteData   = data_q;
    assign shouldWriteText = wr_q;
    assign busy            = busy_q;

endmodule
